// File: rtl/bist_pkg.sv
// Shared BIST definitions: MISR FSM state type and default feedback polynomials.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_t;

  // Default Galois feedback taps (bit i set: MSB is folded into stage i).
  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h1021;
  localparam logic [31:0] POLY32 = 32'h04C1_1DB7;

endpackage

// File: rtl/misr_core.sv
// Galois signature register datapath: seed load, enable, response in, signature out.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY8),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic fb;

  assign fb = q[WIDTH-1];

  // Next signature: shift up, fold MSB into tapped stages, XOR in the response word.
  always_comb begin
    q_next    = '0;
    q_next[0] = (POLY[0] & fb) ^ z[0];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      q_next[i] = q[i-1] ^ (POLY[i] & fb) ^ z[i];
    end
  end

  // Signature register: seed on reset or load, advance only when enabled.
  always_ff @(posedge clk) begin
    if (!rst || load) begin
      q <= SEED;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/misr_sig.sv
// MISR with a LEN-beat compaction window and golden-signature compare.
// Optional build macro MISR_SIG_MASK_EN adds a z_mask input that zeroes
// masked response bits before they reach the signature register.
module misr_sig
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY8),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int unsigned      LEN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             z_valid,
  input  logic [WIDTH-1:0] z,
`ifdef MISR_SIG_MASK_EN
  input  logic [WIDTH-1:0] z_mask,
`endif
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned    CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  misr_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] z_in;
  logic [WIDTH-1:0] q_next;
  logic             load;
  logic             en;

`ifdef MISR_SIG_MASK_EN
  assign z_in = z & ~z_mask;
`else
  assign z_in = z;
`endif

  // start is only honoured outside COMPACT and beats only count inside it,
  // so a simultaneous start and z_valid in IDLE/DONE discards the beat.
  assign load = start && (state != COMPACT);
  assign en   = z_valid && (state == COMPACT);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (en),
    .z      (z_in),
    .q      (q),
    .q_next (q_next)
  );

  // Window control FSM with beat counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= COMPACT;
            cnt   <= '0;
            pass  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COMPACT: begin
          if (z_valid) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (q_next == golden);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misr_sig.sv
// Self-checking bench for misr_sig (WIDTH=8, POLY=0x1D, SEED=0, LEN=3).
module tb_misr_sig;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       z_valid;
  logic [7:0] z;
  logic [7:0] golden;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       pass;
`ifdef MISR_SIG_MASK_EN
  logic [7:0] z_mask;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  misr_sig #(
    .WIDTH (8),
    .POLY  (8'h1D),
    .SEED  (8'h00),
    .LEN   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .z_valid (z_valid),
    .z       (z),
`ifdef MISR_SIG_MASK_EN
    .z_mask  (z_mask),
`endif
    .golden  (golden),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .pass    (pass)
  );

  typedef struct {
    logic       start;
    logic       zv;
    logic [7:0] z;
    logic [7:0] gold;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
    logic       ep;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       b;
    logic       d;
    logic       p;
  } exp_t;

  vec_t       tbl[10];
  exp_t       sb[$];
  logic [7:0] qsb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Galois step written as word arithmetic.
  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [7:0] w);
    logic [7:0] t;
    t = {s[6:0], 1'b0};
    if (s[7]) t = t ^ 8'h1D;
    return t ^ w;
  endfunction

  // One window of three 0xAA beats with 'gap' idle cycles between beats;
  // reports how many cycles after the start edge done was seen.
  task automatic run_window(input int gap, input logic [7:0] gold,
                            output int lat, output logic seen);
    logic [7:0] mq;
    logic [7:0] e;
    int sent;
    int idle;
    logic drove;
    start = 1'b1; z_valid = 1'b0; golden = gold;
    tick();
    start = 1'b0;
    mq = 8'h00; lat = 0; sent = 0; idle = 0; seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      drove = 1'b0;
      if (sent < 3 && idle == 0) begin
        z_valid = 1'b1; z = 8'hAA; sent++; idle = gap; drove = 1'b1;
        mq = model_step(mq, 8'hAA);
        qsb.push_back(mq);
      end else begin
        z_valid = 1'b0;
        if (idle > 0) idle--;
      end
      tick();
      lat++;
      if (drove) begin
        e = qsb.pop_front();
        check("window_q", q, e);
      end
      seen = done;
    end
    z_valid = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int lat_plain;
    int lat_stall;
    logic seen;
    exp_t ex;

    rst = 1'b0; start = 1'b0; z_valid = 1'b0; z = '0; golden = '0;
`ifdef MISR_SIG_MASK_EN
    z_mask = '0;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    rst = 1'b1;

    //              start zv  z      gold   exp_q  busy done pass
    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h71, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hAA, 8'h71, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'hAA, 8'h71, 8'hE3, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'hAA, 8'h71, 8'h71, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'h55, 8'h71, 8'h71, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h55, 8'h70, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'hAA, 8'h70, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'hAA, 8'h70, 8'hE3, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'hAA, 8'h70, 8'h71, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 8'h70, 8'h71, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; z_valid = tbl[i].zv; z = tbl[i].z; golden = tbl[i].gold;
      sb.push_back('{tbl[i].eq, tbl[i].eb, tbl[i].ed, tbl[i].ep});
      tick();
      ex = sb.pop_front();
      check($sformatf("tbl%0d_q", i), q, ex.q);
      check($sformatf("tbl%0d_busy", i), busy, ex.b);
      check($sformatf("tbl%0d_done", i), done, ex.d);
      check($sformatf("tbl%0d_pass", i), pass, ex.p);
    end
    start = 1'b0; z_valid = 1'b0;

    // Unstalled vs stalled window latency and result
    run_window(0, 8'h71, lat_plain, seen);
    check("plain_lat", lat_plain, 3);
    check("plain_q", q, 8'h71);
    check("plain_pass", pass, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("pass_hold", pass, 1);

    run_window(1, 8'h71, lat_stall, seen);
    check("stall_lat", lat_stall, lat_plain + 2);
    check("stall_q", q, 8'h71);
    check("stall_pass", pass, 1);
    tick();

    // Reset mid-window
    start = 1'b1; tick();
    start = 1'b0; z_valid = 1'b1; z = 8'hAA; tick();
    check("mid_beat_q", q, 8'hAA);
    z_valid = 1'b0; rst = 1'b0; tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 0);
    rst = 1'b1; z_valid = 1'b1; z = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_q_hold", q, 8'h00);
      check("idle_no_done", done, 0);
      check("idle_pass", pass, 0);
    end
    z_valid = 1'b0;

`ifdef MISR_SIG_MASK_EN
    z_mask = 8'hFF;
    run_window(0, 8'h00, lat_plain, seen);
    check("mask_q", q, 8'h00);
    check("mask_pass", pass, 1);
    z_mask = 8'h00;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
